// File: rtl/csr_trap_ctrl_if.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl_if
//   Commit-stage handshake between the pipeline commit stage (master) and the
//   CSR/trap controller (slave).
//
//   commit_valid    master -> slave  committing instruction is valid
//   commit_ready    slave  -> master controller accepts the commit this cycle
//   commit_pc       master -> slave  PC of the committing instruction
//   commit_instr    master -> slave  raw 32-bit instruction word
//   commit_rs1_val  master -> slave  rs1 operand value
// ---------------------------------------------------------------------------
interface csr_trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            commit_valid;
    logic            commit_ready;
    logic [XLEN-1:0] commit_pc;
    logic [31:0]     commit_instr;
    logic [XLEN-1:0] commit_rs1_val;

    modport master (
        output commit_valid,
        output commit_pc,
        output commit_instr,
        output commit_rs1_val,
        input  commit_ready
    );

    modport slave (
        input  commit_valid,
        input  commit_pc,
        input  commit_instr,
        input  commit_rs1_val,
        output commit_ready
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
//   Commit-side controller sitting directly in front of the CSR register file.
//   Decodes committing SYSTEM instructions (CSRRW/S/C and immediate forms,
//   ECALL, MRET) and PC misalignment, forms the complete new CSR value, and
//   sequences trap entry: drain outstanding memory, strobe the CSR file, then
//   flush the pipeline and redirect fetch. Other commits pass straight through.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cmt (slave)         commit handshake: valid/ready, pc, instr, rs1 value
//   csr_rdata_i         CSR file combinational read of csr_addr_o
//   csr_next_pc_i       CSR file trap/mret target, valid during the TRAP cycle
//   mem_busy_i          outstanding data-bus transaction
//   csr_addr_o          CSR address (instr[31:20]), held while busy
//   csr_we_o            CSR write strobe, csr_wdata_o the full new value
//   csr_is_ecall_o / csr_is_mret_o / csr_is_misalign_o   trap strobes
//   csr_exception_o     high with the ecall or misalign strobe
//   rd_we_o/rd_addr_o/rd_wdata_o   GPR writeback of the old CSR value
//   flush_o, redirect_valid_o, redirect_pc_o   pipeline kill + fetch redirect
//   mcycle_inc_o        high every cycle while out of reset
// ---------------------------------------------------------------------------
module csr_trap_ctrl #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    csr_trap_ctrl_if.slave    cmt,
    input  logic [XLEN-1:0]   csr_rdata_i,
    input  logic [XLEN-1:0]   csr_next_pc_i,
    input  logic              mem_busy_i,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic              csr_we_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              csr_is_ecall_o,
    output logic              csr_is_mret_o,
    output logic              csr_is_misalign_o,
    output logic              csr_exception_o,
    output logic              rd_we_o,
    output logic [4:0]        rd_addr_o,
    output logic [XLEN-1:0]   rd_wdata_o,
    output logic              flush_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              mcycle_inc_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CSR_WB   = 3'd1,
        S_DRAIN    = 3'd2,
        S_TRAP     = 3'd3,
        S_REDIRECT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_MISALIGN = 2'd0,
        K_ECALL    = 2'd1,
        K_MRET     = 2'd2
    } trap_kind_t;

    // New CSR value: funct3[2] selects the zero-extended 5-bit immediate,
    // funct3[1:0] selects write / set / clear against the old value.
    function automatic logic [XLEN-1:0] csr_new_value(
        input logic [2:0]      funct3,
        input logic [4:0]      uimm,
        input logic [XLEN-1:0] rs1_val,
        input logic [XLEN-1:0] old_val
    );
        logic [XLEN-1:0] src;
        src = funct3[2] ? {{(XLEN-5){1'b0}}, uimm} : rs1_val;
        case (funct3[1:0])
            2'b01:   csr_new_value = src;
            2'b10:   csr_new_value = old_val | src;
            2'b11:   csr_new_value = old_val & ~src;
            default: csr_new_value = old_val;
        endcase
    endfunction

    state_t           state_q, state_d;
    trap_kind_t       kind_q, kind_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CSR_AW-1:0] addr_q, addr_d;
    logic             ready_q, ready_d;
    logic             csr_we_q, csr_we_d;
    logic [XLEN-1:0]  csr_wdata_q, csr_wdata_d;
    logic             ecall_q, ecall_d;
    logic             mret_q, mret_d;
    logic             misalign_q, misalign_d;
    logic             exception_q, exception_d;
    logic             rd_we_q, rd_we_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]  rd_wdata_q, rd_wdata_d;
    logic             flush_q, flush_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             mcycle_q;

    logic [31:0]      instr_s;
    logic [2:0]       funct3_s;
    logic             accept_s;
    logic             misalign_s;
    logic             ecall_s;
    logic             mret_s;
    logic             csr_op_s;
    logic             system_s;

    assign instr_s    = cmt.commit_instr;
    assign funct3_s   = instr_s[14:12];
    assign accept_s   = cmt.commit_valid & ready_q;
    assign misalign_s = (cmt.commit_pc[1:0] != 2'b00);
    assign ecall_s    = (instr_s == 32'h0000_0073);
    assign mret_s     = (instr_s == 32'h3020_0073);
    // funct3 in {1,2,3,5,6,7} is exactly funct3[1:0] != 0
    assign csr_op_s   = (instr_s[6:0] == 7'h73) && (funct3_s[1:0] != 2'b00);
    assign system_s   = misalign_s | ecall_s | mret_s | csr_op_s;

    // Next-state and next-output logic; outputs are registered for the state being entered.
    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        pc_d             = pc_q;
        addr_d           = addr_q;
        csr_we_d         = 1'b0;
        csr_wdata_d      = csr_wdata_q;
        ecall_d          = 1'b0;
        mret_d           = 1'b0;
        misalign_d       = 1'b0;
        exception_d      = 1'b0;
        rd_we_d          = 1'b0;
        rd_addr_d        = rd_addr_q;
        rd_wdata_d       = rd_wdata_q;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s && system_s) begin
                    pc_d   = cmt.commit_pc;
                    addr_d = instr_s[31 -: CSR_AW];
                    if (misalign_s) begin
                        state_d = S_DRAIN;
                        kind_d  = K_MISALIGN;
                    end else if (ecall_s) begin
                        state_d = S_DRAIN;
                        kind_d  = K_ECALL;
                    end else if (mret_s) begin
                        state_d = S_DRAIN;
                        kind_d  = K_MRET;
                    end else begin
                        state_d     = S_CSR_WB;
                        // set/clear with a zero rs1 field leaves the CSR untouched
                        csr_we_d    = (funct3_s[1:0] == 2'b01) || (instr_s[19:15] != 5'd0);
                        csr_wdata_d = csr_new_value(funct3_s, instr_s[19:15],
                                                    cmt.commit_rs1_val, csr_rdata_i);
                        rd_we_d     = (instr_s[11:7] != 5'd0);
                        rd_addr_d   = instr_s[11:7];
                        rd_wdata_d  = csr_rdata_i;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CSR_WB: begin
                state_d          = S_REDIRECT;
                redirect_pc_d    = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
                flush_d          = 1'b1;
                redirect_valid_d = 1'b1;
            end
            S_DRAIN: begin
                if (!mem_busy_i) begin
                    state_d = S_TRAP;
                    case (kind_q)
                        K_ECALL: begin
                            ecall_d     = 1'b1;
                            exception_d = 1'b1;
                        end
                        K_MRET: begin
                            mret_d      = 1'b1;
                        end
                        default: begin
                            misalign_d  = 1'b1;
                            exception_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_TRAP: begin
                state_d          = S_REDIRECT;
                redirect_pc_d    = csr_next_pc_i;
                flush_d          = 1'b1;
                redirect_valid_d = 1'b1;
            end
            S_REDIRECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            kind_q           <= K_MISALIGN;
            pc_q             <= {XLEN{1'b0}};
            addr_q           <= {CSR_AW{1'b0}};
            ready_q          <= 1'b1;
            csr_we_q         <= 1'b0;
            csr_wdata_q      <= {XLEN{1'b0}};
            ecall_q          <= 1'b0;
            mret_q           <= 1'b0;
            misalign_q       <= 1'b0;
            exception_q      <= 1'b0;
            rd_we_q          <= 1'b0;
            rd_addr_q        <= 5'd0;
            rd_wdata_q       <= {XLEN{1'b0}};
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
            mcycle_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            kind_q           <= kind_d;
            pc_q             <= pc_d;
            addr_q           <= addr_d;
            ready_q          <= ready_d;
            csr_we_q         <= csr_we_d;
            csr_wdata_q      <= csr_wdata_d;
            ecall_q          <= ecall_d;
            mret_q           <= mret_d;
            misalign_q       <= misalign_d;
            exception_q      <= exception_d;
            rd_we_q          <= rd_we_d;
            rd_addr_q        <= rd_addr_d;
            rd_wdata_q       <= rd_wdata_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mcycle_q         <= 1'b1;
        end
    end

    // The CSR file reads combinationally from csr_addr_o, so the old value must
    // be available in the accept cycle: present the incoming address while idle,
    // and the captured one for the rest of the sequence.
    assign csr_addr_o        = (state_q == S_IDLE && cmt.commit_valid) ? instr_s[31 -: CSR_AW] : addr_q;
    assign cmt.commit_ready  = ready_q;
    assign csr_we_o          = csr_we_q;
    assign csr_wdata_o       = csr_wdata_q;
    assign csr_is_ecall_o    = ecall_q;
    assign csr_is_mret_o     = mret_q;
    assign csr_is_misalign_o = misalign_q;
    assign csr_exception_o   = exception_q;
    assign rd_we_o           = rd_we_q;
    assign rd_addr_o         = rd_addr_q;
    assign rd_wdata_o        = rd_wdata_q;
    assign flush_o           = flush_q;
    assign redirect_valid_o  = redirect_valid_q;
    assign redirect_pc_o     = redirect_pc_q;
    assign mcycle_inc_o      = mcycle_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_ctrl
//   Self-checking bench for csr_trap_ctrl: directed vectors for CSR writes,
//   trap entry and reset-abort, plus randomized commits checked against a
//   transaction-level reference model of the classification and timing rules.
// ---------------------------------------------------------------------------
module tb_csr_trap_ctrl;
    localparam int XLEN   = 64;
    localparam int CSR_AW = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [XLEN-1:0]   csr_rdata;
    logic [XLEN-1:0]   csr_next_pc;
    logic              mem_busy;
    logic [CSR_AW-1:0] csr_addr;
    logic              csr_we, csr_is_ecall, csr_is_mret, csr_is_misalign, csr_exception;
    logic              rd_we, flush, redirect_valid, mcycle_inc;
    logic [XLEN-1:0]   csr_wdata, rd_wdata, redirect_pc;
    logic [4:0]        rd_addr;

    int checks = 0;
    int errors = 0;

    csr_trap_ctrl_if #(.XLEN(XLEN)) cif ();

    csr_trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .cmt               (cif),
        .csr_rdata_i       (csr_rdata),
        .csr_next_pc_i     (csr_next_pc),
        .mem_busy_i        (mem_busy),
        .csr_addr_o        (csr_addr),
        .csr_we_o          (csr_we),
        .csr_wdata_o       (csr_wdata),
        .csr_is_ecall_o    (csr_is_ecall),
        .csr_is_mret_o     (csr_is_mret),
        .csr_is_misalign_o (csr_is_misalign),
        .csr_exception_o   (csr_exception),
        .rd_we_o           (rd_we),
        .rd_addr_o         (rd_addr),
        .rd_wdata_o        (rd_wdata),
        .flush_o           (flush),
        .redirect_valid_o  (redirect_valid),
        .redirect_pc_o     (redirect_pc),
        .mcycle_inc_o      (mcycle_inc)
    );

    always #5 clk = ~clk;

    // {csr_we, is_ecall, is_mret, is_misalign, exception, rd_we, flush, redirect_valid}
    function automatic logic [7:0] strobes();
        return {csr_we, csr_is_ecall, csr_is_mret, csr_is_misalign,
                csr_exception, rd_we, flush, redirect_valid};
    endfunction

    task automatic drive_commit(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                                input logic [63:0] rs1, input logic [63:0] old);
        cif.commit_valid   = v;
        cif.commit_pc      = pc;
        cif.commit_instr   = ins;
        cif.commit_rs1_val = rs1;
        csr_rdata          = old;
    endtask

    // Junk on the commit port while the controller is busy; it must be ignored.
    task automatic drive_garbage();
        cif.commit_valid   = 1'($urandom_range(0, 1));
        cif.commit_pc      = {$urandom, $urandom};
        cif.commit_instr   = $urandom;
        cif.commit_rs1_val = {$urandom, $urandom};
        csr_rdata          = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        mem_busy    = 1'b0;
        csr_next_pc = 64'h0;
        drive_commit(1'b0, 64'h0, 32'h0, 64'h0, 64'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (cif.commit_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", cif.commit_ready);
        end
        checks++;
        if (strobes() !== 8'h00) begin
            errors++; $display("FAIL reset_strobes got %b want 00000000", strobes());
        end
        checks++;
        if ({csr_addr, csr_wdata, rd_addr, rd_wdata, redirect_pc} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h rd=%h rdw=%h rpc=%h want all 0",
                     csr_addr, csr_wdata, rd_addr, rd_wdata, redirect_pc);
        end
        checks++;
        if (mcycle_inc !== 1'b0) begin
            errors++; $display("FAIL reset_mcycle got %b want 0", mcycle_inc);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mcycle_inc !== 1'b1 || cif.commit_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got mcycle=%b ready=%b want 1 1", mcycle_inc, cif.commit_ready);
        end
    endtask

    task automatic test_csr_vectors();
        logic [31:0] ins  [5];
        logic [63:0] pcs  [5];
        logic [63:0] rs1s [5];
        logic [63:0] olds [5];
        logic [63:0] expw [5];
        logic [63:0] exprpc [5];
        logic        expwe [5];
        ins    = '{{12'h305, 5'd1, 3'd1, 5'd5, 7'h73},    // csrrw  mtvec, x1 -> x5
                   {12'h300, 5'd2, 3'd3, 5'd0, 7'h73},    // csrrc  mstatus, x2 -> x0
                   {12'h341, 5'd0, 3'd2, 5'd3, 7'h73},    // csrrs  mepc, x0 -> x3
                   {12'h344, 5'd0, 3'd7, 5'd7, 7'h73},    // csrrci mip, 0 -> x7
                   {12'h340, 5'd31, 3'd5, 5'd1, 7'h73}};  // csrrwi mscratch, 31 -> x1
        pcs    = '{64'h100, 64'h200, 64'h300, 64'hFFFF_FFFF_FFFF_FFFC, 64'h400};
        rs1s   = '{64'h8000_0000, 64'h08, 64'h0, 64'h1234, 64'hDEAD};
        olds   = '{64'h0, 64'h88, 64'h55, 64'hF0, 64'h1234};
        expw   = '{64'h8000_0000, 64'h80, 64'h55, 64'hF0, 64'h1F};
        expwe  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exprpc = '{64'h104, 64'h204, 64'h304, 64'h0, 64'h404};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_commit(1'b1, pcs[i], ins[i], rs1s[i], olds[i]);
            #1;
            checks++;
            if (csr_addr !== ins[i][31:20]) begin
                errors++; $display("FAIL csr_vec%0d_addr got %h want %h", i, csr_addr, ins[i][31:20]);
            end
            @(negedge clk);
            checks++;
            if (strobes() !== {expwe[i], 4'b0000, (ins[i][11:7] != 5'd0), 2'b00} || cif.commit_ready !== 1'b0) begin
                errors++;
                $display("FAIL csr_vec%0d_wb got strobes=%b ready=%b want %b 0", i, strobes(),
                         cif.commit_ready, {expwe[i], 4'b0000, (ins[i][11:7] != 5'd0), 2'b00});
            end
            checks++;
            if (csr_wdata !== expw[i] || rd_wdata !== olds[i] || rd_addr !== ins[i][11:7]) begin
                errors++;
                $display("FAIL csr_vec%0d_data got wdata=%h rdw=%h rd=%0d want %h %h %0d", i,
                         csr_wdata, rd_wdata, rd_addr, expw[i], olds[i], ins[i][11:7]);
            end
            drive_garbage();
            @(negedge clk);
            checks++;
            if (strobes() !== 8'h03 || redirect_pc !== exprpc[i]) begin
                errors++;
                $display("FAIL csr_vec%0d_redirect got strobes=%b rpc=%h want 00000011 %h", i,
                         strobes(), redirect_pc, exprpc[i]);
            end
            drive_commit(1'b0, 64'h0, 32'h0, 64'h0, 64'h0);
        end
    endtask

    task automatic test_trap_vectors();
        logic [31:0] ins   [4];
        logic [63:0] pcs   [4];
        logic [63:0] nxt   [4];
        int          nbusy [4];
        logic [7:0]  expst [4];
        logic [7:0]  exp_s;
        ins   = '{32'h0000_0073, 32'h0000_0073, 32'h3020_0073, {12'h305, 5'd1, 3'd1, 5'd5, 7'h73}};
        pcs   = '{64'h1000, 64'h1002, 64'h3000, 64'h5003};
        nxt   = '{64'h8000_0100, 64'h8000_0200, 64'h2000, 64'h8000_0300};
        nbusy = '{2, 0, 0, 1};
        expst = '{8'b0100_1000, 8'b0001_1000, 8'b0010_0000, 8'b0001_1000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_commit(1'b1, pcs[i], ins[i], 64'h0, 64'h0);
            mem_busy    = 1'b1;
            csr_next_pc = {$urandom, $urandom};
            for (int c = 1; c <= nbusy[i] + 3; c++) begin
                @(negedge clk);
                exp_s = (c == nbusy[i] + 2) ? expst[i] : (c == nbusy[i] + 3) ? 8'h03 : 8'h00;
                checks++;
                if (strobes() !== exp_s || cif.commit_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL trap_vec%0d_c%0d got strobes=%b ready=%b want %b 0", i, c,
                             strobes(), cif.commit_ready, exp_s);
                end
                if (c == nbusy[i] + 3) begin
                    checks++;
                    if (redirect_pc !== nxt[i]) begin
                        errors++;
                        $display("FAIL trap_vec%0d_rpc got %h want %h", i, redirect_pc, nxt[i]);
                    end
                end
                drive_garbage();
                mem_busy    = (c <= nbusy[i]);
                csr_next_pc = (c == nbusy[i] + 2) ? nxt[i] : {$urandom, $urandom};
            end
            drive_commit(1'b0, 64'h0, 32'h0, 64'h0, 64'h0);
            mem_busy = 1'b0;
        end
    endtask

    task automatic test_reset_in_drain();
        @(negedge clk);
        drive_commit(1'b1, 64'h1000, 32'h0000_0073, 64'h0, 64'h0);
        mem_busy = 1'b1;
        @(negedge clk);
        cif.commit_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cif.commit_ready !== 1'b1 || strobes() !== 8'h00) begin
            errors++;
            $display("FAIL reset_drain got ready=%b strobes=%b want 1 00000000", cif.commit_ready, strobes());
        end
        reset    = 1'b0;
        mem_busy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (cif.commit_ready !== 1'b1 || strobes() !== 8'h00) begin
                errors++;
                $display("FAIL reset_drain_after%0d got ready=%b strobes=%b want 1 00000000", c,
                         cif.commit_ready, strobes());
            end
        end
    endtask

    // Randomized commits against a transaction-level model: the class is
    // derived from the architectural rules, and the expected output trace is
    // laid out as "what happens k cycles after accept".
    task automatic test_random_model();
        typedef enum {C_PASS, C_CSR, C_MIS, C_ECALL, C_MRET} cls_t;
        logic [2:0]  f3tab [6];
        logic [31:0] r, ins;
        logic [63:0] pc, rs1, old, nxt, src, newv, exp_rpc;
        logic [4:0]  uimm;
        logic [2:0]  f3;
        logic        we_e, rdwe_e;
        logic [7:0]  exp_s, trap_s;
        cls_t        cls;
        int          kind, n, last, redir_c;
        f3tab = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 7);
            r    = $urandom;
            pc   = {$urandom, $urandom};
            pc[1:0] = 2'b00;
            rs1  = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
            old  = {$urandom, $urandom};
            nxt  = {$urandom, $urandom};
            f3   = f3tab[$urandom_range(0, 5)];
            ins  = {r[31:20], r[19:15], f3, r[11:7], 7'h73};
            if ($urandom_range(0, 3) == 0) ins[19:15] = 5'd0;
            case (kind)
                3:       ins = 32'h0000_0073;
                4:       ins = 32'h3020_0073;
                5:       ins = {r[31:7], 7'h33};
                6:       begin
                             pc[1:0] = 2'($urandom_range(1, 3));
                             if (r[0]) ins = 32'h0000_0073;
                         end
                7:       ins = {r[31:15], (r[0] ? 3'd4 : 3'd0), r[11:7], 7'h73};
                default: ;
            endcase

            if (pc % 4 != 0)                  cls = C_MIS;
            else if (ins == 32'h0000_0073)    cls = C_ECALL;
            else if (ins == 32'h3020_0073)    cls = C_MRET;
            else if (ins[6:0] == 7'h73 && ins[14:12] != 3'd0 && ins[14:12] != 3'd4) cls = C_CSR;
            else                              cls = C_PASS;

            uimm = ins[19:15];
            src  = (ins[14:12] >= 3'd5) ? 64'(uimm) : rs1;
            if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)      newv = src;
            else if (ins[14:12] == 3'd2 || ins[14:12] == 3'd6) newv = old | src;
            else                                               newv = old & ~src;
            we_e   = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) || (uimm != 5'd0);
            rdwe_e = (ins[11:7] != 5'd0);
            trap_s = (cls == C_MIS) ? 8'b0001_1000 : (cls == C_ECALL) ? 8'b0100_1000 : 8'b0010_0000;
            n      = $urandom_range(0, 4);
            if (cls == C_PASS)     begin last = 0;     redir_c = -1;    exp_rpc = 64'h0;     end
            else if (cls == C_CSR) begin last = 2;     redir_c = 2;     exp_rpc = pc + 64'd4; end
            else                   begin last = n + 3; redir_c = n + 3; exp_rpc = nxt;       end

            @(negedge clk);
            checks++;
            if (cif.commit_ready !== 1'b1 || strobes() !== 8'h00) begin
                errors++;
                $display("FAIL rnd%0d_idle got ready=%b strobes=%b want 1 00000000", t,
                         cif.commit_ready, strobes());
            end
            drive_commit(1'b1, pc, ins, rs1, old);
            mem_busy    = 1'($urandom_range(0, 1));
            csr_next_pc = {$urandom, $urandom};
            #1;
            checks++;
            if (csr_addr !== ins[31:20]) begin
                errors++; $display("FAIL rnd%0d_addr got %h want %h", t, csr_addr, ins[31:20]);
            end
            for (int c = 1; c <= last; c++) begin
                @(negedge clk);
                if (cls == C_CSR) exp_s = (c == 1) ? {we_e, 4'b0000, rdwe_e, 2'b00} : 8'h03;
                else exp_s = (c == n + 2) ? trap_s : (c == n + 3) ? 8'h03 : 8'h00;
                checks++;
                if (strobes() !== exp_s || cif.commit_ready !== 1'b0 || csr_addr !== ins[31:20]) begin
                    errors++;
                    $display("FAIL rnd%0d_c%0d got strobes=%b ready=%b addr=%h want %b 0 %h", t, c,
                             strobes(), cif.commit_ready, csr_addr, exp_s, ins[31:20]);
                end
                if (cls == C_CSR && c == 1) begin
                    checks++;
                    if (csr_wdata !== newv || rd_wdata !== old || rd_addr !== ins[11:7]) begin
                        errors++;
                        $display("FAIL rnd%0d_csrdata got wdata=%h rdw=%h rd=%0d want %h %h %0d", t,
                                 csr_wdata, rd_wdata, rd_addr, newv, old, ins[11:7]);
                    end
                end
                if (c == redir_c) begin
                    checks++;
                    if (redirect_pc !== exp_rpc) begin
                        errors++; $display("FAIL rnd%0d_rpc got %h want %h", t, redirect_pc, exp_rpc);
                    end
                end
                drive_garbage();
                mem_busy    = (cls == C_CSR) ? 1'($urandom_range(0, 1)) : (c <= n);
                csr_next_pc = (cls != C_CSR && c == n + 2) ? nxt : {$urandom, $urandom};
            end
        end
        @(negedge clk);
        drive_commit(1'b0, 64'h0, 32'h0, 64'h0, 64'h0);
        mem_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_csr_vectors();
        test_trap_vectors();
        test_reset_in_drain();
        test_random_model();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
